// File: rtl/spi_ram_pkg.sv
// Shared constants for the SPI/host RAM arbiter: opcodes, FSM encoding, default widths.
package spi_ram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RDATA = 2'b11;

  localparam logic GNT_SPI  = 1'b0;
  localparam logic GNT_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPI_ACC  = 2'd1,
    HOST_ACC = 2'd2,
    RD_WAIT  = 2'd3
  } state_t;

  // Odd opcodes (data write / data read) are the only ones that touch the RAM.
  function automatic logic op_needs_ram(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/spi_cmd_capture.sv
// Latches one SPI command per rising edge of rx_valid and tracks pending/overrun status.
module spi_cmd_capture
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W+1:0] rx_data,
  input  logic              rx_valid,
  input  logic              clr,
  output logic [ADDR_W+1:0] cmd,
  output logic              pend,
  output logic              ovf,
  output logic              cap
);

  logic              rx_prev_q, rx_prev_d;
  logic [ADDR_W+1:0] cmd_q, cmd_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;

  assign cap = rx_valid & ~rx_prev_q;

  // A fresh edge beats a same-cycle clear: the newer command must stay pending.
  always_comb begin
    rx_prev_d = rx_valid;
    cmd_d     = cmd_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    if (clr) pend_d = 1'b0;
    if (cap) begin
      cmd_d  = rx_data;
      pend_d = 1'b1;
      if (pend_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_prev_q <= 1'b0;
      cmd_q     <= '0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rx_prev_q <= rx_prev_d;
      cmd_q     <= cmd_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
    end
  end

  assign cmd  = cmd_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between an SPI command slave and a host port.
// One access in flight at a time; contested cycles alternate between requesters.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              spi_ovf
);

  logic [ADDR_W+1:0] cmd;
  logic              spi_pend, spi_cap, spi_clr;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_pl;

  spi_cmd_capture #(.ADDR_W(ADDR_W)) u_capture (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .clr      (spi_clr),
    .cmd      (cmd),
    .pend     (spi_pend),
    .ovf      (spi_ovf),
    .cap      (spi_cap)
  );

  assign cmd_op = cmd[ADDR_W+1:ADDR_W];
  assign cmd_pl = cmd[ADDR_W-1:0];

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              acc_rd_q, acc_rd_d;
  logic              rd_spi_q, rd_spi_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              host_gnt_q, host_gnt_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              spi_need, spi_go, spi_is_wr;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    acc_rd_d      = acc_rd_q;
    rd_spi_d      = rd_spi_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = '0;
    ram_wdata_d   = '0;
    host_gnt_d    = 1'b0;
    host_rvalid_d = 1'b0;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q & ~spi_cap;
    spi_clr       = 1'b0;
    spi_need      = spi_pend & op_needs_ram(cmd_op);
    spi_go        = spi_need & (~host_req | (last_grant_q == GNT_HOST));
    spi_is_wr     = (cmd_op == OP_WDATA);

    unique case (state_q)
      IDLE: begin
        // Address loads retire here directly; they may overlap a host grant.
        if (spi_pend && !op_needs_ram(cmd_op)) begin
          spi_clr = 1'b1;
          if (cmd_op == OP_WADDR) wr_addr_d = cmd_pl;
          else                    rd_addr_d = cmd_pl;
        end
        // last_grant only moves on contested cycles, so ties alternate.
        if (spi_need && host_req) last_grant_d = spi_go ? GNT_SPI : GNT_HOST;
        if (spi_go) begin
          state_d     = SPI_ACC;
          ram_en_d    = 1'b1;
          ram_we_d    = spi_is_wr;
          ram_addr_d  = spi_is_wr ? wr_addr_q : rd_addr_q;
          ram_wdata_d = spi_is_wr ? DATA_W'(cmd_pl) : '0;
          acc_rd_d    = ~spi_is_wr;
          rd_spi_d    = 1'b1;
        end else if (host_req) begin
          state_d     = HOST_ACC;
          ram_en_d    = 1'b1;
          ram_we_d    = host_we;
          ram_addr_d  = host_addr;
          ram_wdata_d = host_wdata;
          host_gnt_d  = 1'b1;
          acc_rd_d    = ~host_we;
          rd_spi_d    = 1'b0;
        end
      end
      SPI_ACC: begin
        spi_clr = 1'b1;
        state_d = acc_rd_q ? RD_WAIT : IDLE;
      end
      HOST_ACC: begin
        state_d       = acc_rd_q ? RD_WAIT : IDLE;
        host_rvalid_d = acc_rd_q;
      end
      RD_WAIT: begin
        if (rd_spi_q) begin
          tx_data_d  = ram_rdata;
          tx_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GNT_HOST;
      acc_rd_q      <= 1'b0;
      rd_spi_q      <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      acc_rd_q      <= acc_rd_d;
      rd_spi_q      <= rd_spi_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      host_gnt_q    <= host_gnt_d;
      host_rvalid_q <= host_rvalid_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
    end
  end

  // Host read data is passed straight from the RAM during RD_WAIT to meet gnt+1;
  // a reset arriving in that cycle suppresses the pulse.
  assign host_rvalid = host_rvalid_q & rst_n;
  assign host_rdata  = host_rvalid ? ram_rdata : '0;
  assign host_gnt    = host_gnt_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench: stimulus pushes expected RAM writes / read data, a negedge monitor pops and compares.
module tb_spi_ram_arbiter;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = '0, host_wdata = '0;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       spi_ovf;

  spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment RAM: registered read, contents preloaded on the first clock.
  logic [7:0] mem [256];
  logic       mem_loaded = 1'b0;
  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 29) + 7);
  endfunction
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model: architectural RAM contents and the two SPI address registers.
  logic [7:0]  ref_mem [256];
  logic [7:0]  m_wr_addr = '0, m_rd_addr = '0;
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  exp_hr_q[$];
  logic        trace_q[$];

  int n_cmp = 0, n_err = 0, n_wr = 0;
  int cap_cyc = 0, rise_cyc = 0;
  logic tx_prev = 1'b0, gnt_prev = 1'b0, ram_en_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got an unexpected DUT event, required none", name);
  endtask

  always @(negedge clk) begin
    if (ram_en) begin
      trace_q.push_back(host_gnt);
      check("ram_en_single_cycle", 32'(ram_en_prev), 32'd0);
      if (ram_we) begin
        n_wr++;
        if (exp_wr_q.size() == 0) fail_now("ram_write_unexpected");
        else check("ram_write", 32'({ram_addr, ram_wdata}), 32'(exp_wr_q.pop_front()));
        $display("ram write addr=%02h data=%02h", ram_addr, ram_wdata);
      end
    end
    if (host_gnt)
      check("gnt_ram_access", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, host_we, host_addr}));
    if (host_rvalid) begin
      check("rvalid_one_after_gnt", 32'(gnt_prev), 32'd1);
      if (exp_hr_q.size() == 0) fail_now("host_rvalid_unexpected");
      else check("host_rdata", 32'(host_rdata), 32'(exp_hr_q.pop_front()));
      $display("host read data=%02h", host_rdata);
    end
    if (tx_valid && !tx_prev) begin
      rise_cyc = cyc;
      if (exp_tx_q.size() == 0) fail_now("tx_valid_unexpected");
      else check("tx_data", 32'(tx_data), 32'(exp_tx_q.pop_front()));
      $display("spi read data=%02h", tx_data);
    end
    tx_prev     = tx_valid;
    gnt_prev    = host_gnt;
    ram_en_prev = ram_en;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_tx"}, 32'({tx_valid, tx_data}), 32'd0);
    check({tag, "_host"}, 32'({host_gnt, host_rvalid, host_rdata}), 32'd0);
    check({tag, "_ram"}, 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);
    check({tag, "_ovf"}, 32'(spi_ovf), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; rx_valid = 1'b0; host_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_wr_addr = '0;
    m_rd_addr = '0;
    $display("reset");
  endtask

  task automatic spi_cmd(input logic [1:0] op, input logic [7:0] pl, input int hold);
    @(posedge clk); #1;
    rx_data  = {op, pl};
    rx_valid = 1'b1;
    cap_cyc  = cyc + 1;
    case (op)
      OP_WADDR: m_wr_addr = pl;
      OP_WDATA: begin ref_mem[m_wr_addr] = pl; exp_wr_q.push_back({m_wr_addr, pl}); end
      OP_RADDR: m_rd_addr = pl;
      default:  exp_tx_q.push_back(ref_mem[m_rd_addr]);
    endcase
    repeat (hold) @(posedge clk);
    #1 rx_valid = 1'b0;
    $display("spi cmd op=%0d payload=%02h", op, pl);
  endtask

  task automatic host_acc(input logic we, input logic [7:0] a, input logic [7:0] d);
    logic got;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    if (we) begin ref_mem[a] = d; exp_wr_q.push_back({a, d}); end
    else exp_hr_q.push_back(ref_mem[a]);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = host_gnt;
    end
    check("host_gnt_within_budget", 32'(got), 32'd1);
    @(posedge clk); #1 host_req = 1'b0;
    $display("host %s addr=%02h data=%02h", we ? "write" : "read", a, d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic got;
    logic exp_order [4];
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    do_reset();
    @(negedge clk);
    check_all_zero("reset");

    // Address load followed by data write gives exactly one RAM write.
    w0 = n_wr;
    spi_cmd(OP_WADDR, 8'h2A, 1);
    spi_cmd(OP_WDATA, 8'h5C, 1);
    repeat (6) @(negedge clk);
    check("one_write_00_01", 32'(n_wr - w0), 32'd1);

    // Uncontested SPI read: 3 cycles from capture edge, held until the next command.
    spi_cmd(OP_RADDR, 8'h2A, 1);
    spi_cmd(OP_RDATA, 8'h00, 1);
    repeat (8) @(negedge clk);
    check("spi_read_latency", 32'(rise_cyc - cap_cyc), 32'd3);
    check("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h5C}));
    spi_cmd(OP_WADDR, 8'h2A, 1);
    @(negedge clk);
    check("tx_clear_on_cmd", 32'(tx_valid), 32'd0);

    // rx_valid held high for 5 cycles is a single command.
    w0 = n_wr;
    spi_cmd(OP_WDATA, 8'h77, 5);
    repeat (6) @(negedge clk);
    check("one_write_long_valid", 32'(n_wr - w0), 32'd1);
    check("no_ovf_yet", 32'(spi_ovf), 32'd0);

    // Two simultaneous pairs: SPI wins the first tie, host the second.
    do_reset();
    trace_q.delete();
    fork
      spi_cmd(OP_RDATA, 8'h00, 1);
      begin @(posedge clk); host_acc(1'b0, 8'h10, 8'h00); end
    join
    repeat (8) @(negedge clk);
    fork
      spi_cmd(OP_RDATA, 8'h00, 1);
      begin @(posedge clk); host_acc(1'b0, 8'h10, 8'h00); end
    join
    repeat (8) @(negedge clk);
    exp_order = '{1'b0, 1'b1, 1'b1, 1'b0};
    check("arb_access_count", 32'(trace_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < trace_q.size(); i++)
      check("arb_order_host_bit", 32'(trace_q[i]), 32'(exp_order[i]));

    // Two SPI edges while a host read occupies the RAM: overrun, only the second runs.
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h33;
    exp_hr_q.push_back(ref_mem[8'h33]);
    rx_data = {OP_WDATA, 8'h11}; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; host_req = 1'b0;
    @(posedge clk); #1;
    rx_data = {OP_WDATA, 8'h99}; rx_valid = 1'b1;
    ref_mem[m_wr_addr] = 8'h99;
    exp_wr_q.push_back({m_wr_addr, 8'h99});
    @(posedge clk); #1 rx_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("ovf_set", 32'(spi_ovf), 32'd1);

    // Reset during RD_WAIT of a host read: no rvalid; held request served afterwards.
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = host_gnt;
    end
    check("gnt_before_reset", 32'(got), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("no_rvalid_in_reset", 32'(host_rvalid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_wr_addr = '0;
    m_rd_addr = '0;
    exp_hr_q.push_back(ref_mem[8'h10]);
    @(negedge clk);
    check_all_zero("after_midreset");
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = host_gnt;
    end
    check("held_req_served", 32'(got), 32'd1);
    @(posedge clk); #1 host_req = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized serial traffic against the reference model.
    for (int it = 0; it < 200; it++) begin
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: spi_cmd(OP_WADDR, 8'($urandom_range(0, 15)), 1);
        1: spi_cmd(OP_RADDR, 8'($urandom_range(0, 15)), 1);
        2: spi_cmd(OP_WDATA, 8'($urandom), $urandom_range(1, 3));
        3: spi_cmd(OP_RDATA, 8'($urandom), 1);
        4: host_acc(1'b1, 8'($urandom_range(0, 15)), 8'($urandom));
        default: host_acc(1'b0, 8'($urandom_range(0, 15)), 8'h00);
      endcase
      if (sel < 4) repeat (5) @(posedge clk);
      else repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (10) @(negedge clk);
    check("drain_wr", 32'(exp_wr_q.size()), 32'd0);
    check("drain_tx", 32'(exp_tx_q.size()), 32'd0);
    check("drain_host", 32'(exp_hr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
